// File: rtl/cbfp_pkg.sv
// Shared types for the CBFP / butterfly datapath: lane and beat formats, delay-buffer FSM states.
package cbfp_pkg;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned NCHAN  = 16;

    typedef logic signed [DATA_W-1:0] lane_t;

    typedef struct packed {
        lane_t [NCHAN-1:0] im;
        lane_t [NCHAN-1:0] re;
    } beat_t;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } bfly_state_e;

endpackage

// File: rtl/bfly_delay_buffer_mem.sv
// Beat storage for the butterfly delay buffer: DEPTH words, one write port, one combinational read.
module bfly_buf_mem #(
    parameter int unsigned WIDTH = 384,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    // Contents are never reset; every word is rewritten in FILL before PAIR reads it.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/bfly_delay_buffer.sv
// Pairs beats DEPTH valid beats apart for the next radix-2 stage (top = earlier, bot = later).
// Optional synchronous realignment input 'flush' when BFLY_BUF_FLUSH_EN is defined.
module bfly_delay_buffer
    import cbfp_pkg::*;
#(
    parameter int unsigned DATA_W = cbfp_pkg::DATA_W,
    parameter int unsigned NCHAN  = cbfp_pkg::NCHAN,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                               clk,
    input  logic                               rstn,
`ifdef BFLY_BUF_FLUSH_EN
    input  logic                               flush,
`endif
    input  logic                               valid_in,
    input  logic signed [NCHAN-1:0][DATA_W-1:0] data_re_in,
    input  logic signed [NCHAN-1:0][DATA_W-1:0] data_im_in,
    output logic                               valid_out,
    output logic signed [NCHAN-1:0][DATA_W-1:0] top_re_out,
    output logic signed [NCHAN-1:0][DATA_W-1:0] top_im_out,
    output logic signed [NCHAN-1:0][DATA_W-1:0] bot_re_out,
    output logic signed [NCHAN-1:0][DATA_W-1:0] bot_im_out,
    output logic                               sop_out
);

    localparam int unsigned CntW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LaneW = NCHAN * DATA_W;
    localparam int unsigned BeatW = 2 * LaneW;
    localparam logic [CntW-1:0] CntLast = CntW'(DEPTH - 1);

    bfly_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mem_we;
    logic            pair_beat;
    logic [BeatW-1:0] mem_wdata, mem_rdata;

    logic valid_q, sop_q;
    logic signed [NCHAN-1:0][DATA_W-1:0] top_re_q, top_im_q, bot_re_q, bot_im_q;

    assign mem_wdata = {data_im_in, data_re_in};

    bfly_buf_mem #(
        .WIDTH (BeatW),
        .DEPTH (DEPTH),
        .AW    (CntW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (cnt_q),
        .wdata (mem_wdata),
        .raddr (cnt_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        pair_beat = 1'b0;
        if (valid_in) begin
            mem_we    = (state_q == FILL);
            pair_beat = (state_q == PAIR);
            if (cnt_q == CntLast) begin
                cnt_d = '0;
                if (state_q == FILL) begin
                    state_d = PAIR;
                end else begin
                    state_d = FILL;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`ifdef BFLY_BUF_FLUSH_EN
        // Flush wins over a concurrent beat, which is dropped entirely.
        if (flush) begin
            state_d   = FILL;
            cnt_d     = '0;
            mem_we    = 1'b0;
            pair_beat = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= FILL;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            top_re_q <= '0;
            top_im_q <= '0;
            bot_re_q <= '0;
            bot_im_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= pair_beat;
            sop_q   <= pair_beat && (cnt_q == '0);
            if (pair_beat) begin
                top_re_q <= mem_rdata[LaneW-1:0];
                top_im_q <= mem_rdata[BeatW-1:LaneW];
                bot_re_q <= data_re_in;
                bot_im_q <= data_im_in;
            end
        end
    end

    assign valid_out  = valid_q;
    assign sop_out    = sop_q;
    assign top_re_out = top_re_q;
    assign top_im_out = top_im_q;
    assign bot_re_out = bot_re_q;
    assign bot_im_out = bot_im_q;

endmodule

// File: tb/tb_bfly_delay_buffer.sv
// Self-checking bench for bfly_delay_buffer (DEPTH=16 and DEPTH=1 instances).
// Define BFLY_BUF_FLUSH_EN to also exercise the flush input.
module tb_bfly_delay_buffer;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned NCHAN  = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned LW     = NCHAN * DATA_W;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    logic          valid_in = 1'b0;
    logic [LW-1:0] data_re_in = '0, data_im_in = '0;
    logic          valid_out, sop_out;
    logic [LW-1:0] top_re_out, top_im_out, bot_re_out, bot_im_out;

    logic          v1_in = 1'b0;
    logic [LW-1:0] re1_in = '0, im1_in = '0;
    logic          v1_out, sop1_out;
    logic [LW-1:0] top_re1, top_im1, bot_re1, bot_im1;

    bfly_delay_buffer #(.DATA_W(DATA_W), .NCHAN(NCHAN), .DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
`ifdef BFLY_BUF_FLUSH_EN
        .flush      (flush),
`endif
        .valid_in   (valid_in),
        .data_re_in (data_re_in),
        .data_im_in (data_im_in),
        .valid_out  (valid_out),
        .top_re_out (top_re_out),
        .top_im_out (top_im_out),
        .bot_re_out (bot_re_out),
        .bot_im_out (bot_im_out),
        .sop_out    (sop_out)
    );

    bfly_delay_buffer #(.DATA_W(DATA_W), .NCHAN(NCHAN), .DEPTH(1)) u_dut1 (
        .clk        (clk),
        .rstn       (rstn),
`ifdef BFLY_BUF_FLUSH_EN
        .flush      (1'b0),
`endif
        .valid_in   (v1_in),
        .data_re_in (re1_in),
        .data_im_in (im1_in),
        .valid_out  (v1_out),
        .top_re_out (top_re1),
        .top_im_out (top_im1),
        .bot_re_out (bot_re1),
        .bot_im_out (bot_im1),
        .sop_out    (sop1_out)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: absolute valid-beat index since the last realignment plus full history.
    int unsigned   vcnt = 0;
    logic [LW-1:0] hist_re[$], hist_im[$];
    logic          exp_valid, exp_sop;
    logic [LW-1:0] exp_top_re = '0, exp_top_im = '0, exp_bot_re = '0, exp_bot_im = '0;
    int            n_valid = 0, n_sop = 0, cyc = 0;
    int            sop_cyc[$];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_beat();
        logic [LW-1:0] b;
        for (int j = 0; j < NCHAN; j++) b[j*DATA_W +: DATA_W] = DATA_W'($urandom);
        return b;
    endfunction

    task automatic model_clear();
        vcnt = 0;
        hist_re.delete();
        hist_im.delete();
    endtask

    task automatic step(input bit v, input logic [LW-1:0] re, input logic [LW-1:0] im,
                        input bit fl);
        int unsigned off;
        valid_in   = v;
        data_re_in = re;
        data_im_in = im;
        flush      = fl;
        exp_valid  = 1'b0;
        exp_sop    = 1'b0;
        if (fl) begin
            model_clear();
        end else if (v) begin
            off = vcnt % (2 * DEPTH);
            if (off >= DEPTH) begin
                exp_valid  = 1'b1;
                exp_sop    = (off == DEPTH);
                exp_top_re = hist_re[vcnt-DEPTH];
                exp_top_im = hist_im[vcnt-DEPTH];
                exp_bot_re = re;
                exp_bot_im = im;
            end
            hist_re.push_back(re);
            hist_im.push_back(im);
            vcnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk1("valid_out", valid_out, exp_valid);
        chk1("sop_out", sop_out, exp_sop);
        chkw("top_re", top_re_out, exp_top_re);
        chkw("top_im", top_im_out, exp_top_im);
        chkw("bot_re", bot_re_out, exp_bot_re);
        chkw("bot_im", bot_im_out, exp_bot_im);
        if (valid_out === 1'b1) n_valid++;
        if (sop_out === 1'b1) begin
            n_sop++;
            sop_cyc.push_back(cyc);
        end
        valid_in = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        valid_in = 1'b0;
        v1_in    = 1'b0;
        #1;
        model_clear();
        exp_top_re = '0; exp_top_im = '0; exp_bot_re = '0; exp_bot_im = '0;
        chk1("rst_valid", valid_out, 1'b0);
        chk1("rst_sop", sop_out, 1'b0);
        chkw("rst_top_re", top_re_out, '0);
        chkw("rst_bot_im", bot_im_out, '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic step1(input bit v, input logic [LW-1:0] re, input logic [LW-1:0] im);
        v1_in  = v;
        re1_in = re;
        im1_in = im;
        @(posedge clk);
        #1;
        v1_in = 1'b0;
    endtask

    initial begin
        logic [LW-1:0] pre, pim;
        logic [LW-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
        int sent;

        do_reset();

        // Single section with a counting pattern.
        for (int k = 0; k < 2 * DEPTH; k++) begin
            for (int j = 0; j < NCHAN; j++) begin
                pre[j*DATA_W +: DATA_W] = DATA_W'(16 * k + j);
                pim[j*DATA_W +: DATA_W] = DATA_W'(-(16 * k + j));
            end
            step(1'b1, pre, pim, 1'b0);
            if (k == DEPTH) begin
                chki("first_top_re0", int'($signed(top_re_out[DATA_W-1:0])), 0);
                chki("first_bot_re0", int'($signed(bot_re_out[DATA_W-1:0])), 256);
                chki("first_bot_im0", int'($signed(bot_im_out[DATA_W-1:0])), -256);
            end
        end
        step(1'b0, '0, '0, 1'b0);

        // Three back-to-back random sections.
        do_reset();
        n_sop = 0;
        sop_cyc.delete();
        for (int k = 0; k < 3 * 2 * DEPTH; k++) step(1'b1, rnd_beat(), rnd_beat(), 1'b0);
        chki("sop_count", n_sop, 3);
        if (sop_cyc.size() >= 3) begin
            chki("sop_gap01", sop_cyc[1] - sop_cyc[0], 32);
            chki("sop_gap12", sop_cyc[2] - sop_cyc[1], 32);
        end

        // Four sections with ~30% idle cycles.
        do_reset();
        n_valid = 0;
        sent = 0;
        for (int it = 0; it < 2000 && sent < 4 * 2 * DEPTH; it++) begin
            if ($urandom_range(99) < 30) begin
                step(1'b0, rnd_beat(), rnd_beat(), 1'b0);
            end else begin
                step(1'b1, rnd_beat(), rnd_beat(), 1'b0);
                sent++;
            end
        end
        chki("gap_sent", sent, 4 * 2 * DEPTH);
        chki("valid_count", n_valid, 64);

        // Reset after 10 FILL beats, then a fresh section.
        for (int k = 0; k < 10; k++) step(1'b1, rnd_beat(), rnd_beat(), 1'b0);
        do_reset();
        for (int k = 0; k < 2 * DEPTH; k++) step(1'b1, rnd_beat(), rnd_beat(), 1'b0);

        // DEPTH=1 instance: A,B,(idle),C,D.
        a_re = rnd_beat(); a_im = rnd_beat(); b_re = rnd_beat(); b_im = rnd_beat();
        c_re = rnd_beat(); c_im = rnd_beat(); d_re = rnd_beat(); d_im = rnd_beat();
        step1(1'b1, a_re, a_im);
        chk1("d1_a_valid", v1_out, 1'b0);
        step1(1'b1, b_re, b_im);
        chk1("d1_b_valid", v1_out, 1'b1);
        chk1("d1_b_sop", sop1_out, 1'b1);
        chkw("d1_b_top_re", top_re1, a_re);
        chkw("d1_b_top_im", top_im1, a_im);
        chkw("d1_b_bot_re", bot_re1, b_re);
        chkw("d1_b_bot_im", bot_im1, b_im);
        step1(1'b0, '0, '0);
        chk1("d1_idle_valid", v1_out, 1'b0);
        chkw("d1_idle_hold", top_re1, a_re);
        step1(1'b1, c_re, c_im);
        chk1("d1_c_valid", v1_out, 1'b0);
        step1(1'b1, d_re, d_im);
        chk1("d1_d_valid", v1_out, 1'b1);
        chk1("d1_d_sop", sop1_out, 1'b1);
        chkw("d1_d_top_re", top_re1, c_re);
        chkw("d1_d_top_im", top_im1, c_im);
        chkw("d1_d_bot_re", bot_re1, d_re);
        chkw("d1_d_bot_im", bot_im1, d_im);

`ifdef BFLY_BUF_FLUSH_EN
        // Flush on PAIR beat 5 drops that beat and restarts at FILL entry 0.
        do_reset();
        for (int k = 0; k < DEPTH + 5; k++) step(1'b1, rnd_beat(), rnd_beat(), 1'b0);
        step(1'b1, rnd_beat(), rnd_beat(), 1'b1);
        n_valid = 0;
        for (int k = 0; k < 2 * 2 * DEPTH; k++) step(1'b1, rnd_beat(), rnd_beat(), 1'b0);
        chki("flush_valid_count", n_valid, 32);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
